// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: idle/fault
// instruction word, loader state encoding and fault cause codes.
package imem_pkg;

  // add x0,x0,x0 -- returned on fault, flush, idle and while loading
  localparam logic [31:0] NOP_INST = 32'h00000033;

  // Fault cause codes, reserved for a future mcause path
  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ACCESS     = 4'd1;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_ACC  = 2'd1,
    L_WR   = 2'd2
  } ld_state_t;

endpackage

// File: rtl/imem_byte_loader.sv
// Byte-serial program loader: assembles little-endian bytes into 32-bit
// words and emits one array write per word, starting at word 0.
//
// Handshake: a byte is transferred on a rising edge where ld_valid=1 and
// ld_ready=1; ld_ready depends only on the FSM state, never on ld_valid.
// ld_start and ld_end are single-cycle pulses; ld_start wins over
// everything (restart), ld_end wins over a byte offered in the same cycle.
module imem_byte_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic          ld_end,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic [AW:0]   ld_words,
  output ld_state_t     state
);

  localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

  ld_state_t   state_q, state_d;
  logic [1:0]  lane_q;
  logic [31:0] asm_q;
  logic [AW:0] ptr_q;
  logic        accept;

  assign accept   = (state_q == L_ACC) && ld_valid && !ld_end && !ld_start;
  // a restart in L_WR drops the pending word
  assign wr_en    = (state_q == L_WR) && !ld_start;
  assign wr_addr  = ptr_q[AW-1:0];
  assign wr_data  = asm_q;
  assign ld_ready = (state_q == L_ACC);
  assign ld_busy  = (state_q != L_IDLE);
  assign ld_words = ptr_q;
  assign state    = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= L_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      L_IDLE: if (ld_start) state_d = L_ACC;
      L_ACC: begin
        if (ld_start)                     state_d = L_ACC;
        else if (ld_end)                  state_d = L_IDLE;
        else if (accept && lane_q == 2'd3) state_d = L_WR;
      end
      L_WR: begin
        if (ld_start)                          state_d = L_ACC;
        else if (ld_end || ptr_q == LAST_PTR)  state_d = L_IDLE;
        else                                   state_d = L_ACC;
      end
      default: state_d = L_IDLE;
    endcase
  end

  // Lane counter, word assembly register and write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      asm_q  <= 32'd0;
      ptr_q  <= '0;
    end else if (ld_start) begin
      lane_q <= 2'd0;
      ptr_q  <= '0;
    end else begin
      // ld_end drops a partial word by rewinding the lane
      if (state_q == L_ACC && ld_end) begin
        lane_q <= 2'd0;
      end else if (accept) begin
        asm_q[{lane_q, 3'b000} +: 8] <= ld_byte;
        lane_q <= lane_q + 2'd1;
      end
      if (wr_en) ptr_q <= ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Synchronous-read instruction memory with a registered fetch port
// (stall/flush/fault) and a run-time byte loader.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_INST = imem_pkg::NOP_INST,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_req,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic            stall,
  input  logic            flush,
  output logic [31:0]     inst_out,
  output logic            inst_valid,
  output logic            fault,
  input  logic            ld_start,
  input  logic            ld_end,
  input  logic            ld_valid,
  input  logic [7:0]      ld_byte,
  output logic            ld_ready,
  output logic            ld_busy,
  output logic [AW:0]     ld_words,
  output ld_state_t       ld_state
);

  // Power-up content; reset never touches the array
  logic [31:0] mem [DEPTH] = '{default: NOP_INST};

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW-1:0] idx;
  logic          bad_pc;
  logic          blocked;

  imem_byte_loader #(.DEPTH(DEPTH)) u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_end   (ld_end),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_words (ld_words),
    .state    (ld_state)
  );

  assign idx     = fetch_pc[2 +: AW];
  assign bad_pc  = (|fetch_pc[1:0]) || (|fetch_pc[PC_W-1:AW+2]);
  // a fetch in the same cycle as ld_start is lost
  assign blocked = ld_busy || ld_start;

  // Array write port, driven only by the loader
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Fetch register: flush > load block > stall > request > idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end else if (flush || blocked) begin
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end else if (stall) begin
      inst_out   <= inst_out;
      inst_valid <= inst_valid;
      fault      <= fault;
    end else if (fetch_req) begin
      inst_out   <= bad_pc ? NOP_INST : mem[idx];
      inst_valid <= 1'b1;
      fault      <= bad_pc;
    end else begin
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: fetch port, stall/flush, fault decode,
// partial and full program loads, reset during a load.
module tb_imem_loadable;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam logic [31:0] NOP = 32'h00000033;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic          stall;
  logic          flush;
  logic [31:0]   inst_out;
  logic          inst_valid;
  logic          fault;
  logic          ld_start;
  logic          ld_end;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_ready;
  logic          ld_busy;
  logic [AW:0]   ld_words;
  ld_state_t     ld_state;

  int checks   = 0;
  int failures = 0;

  // {inst_valid, fault, inst_out}
  logic [33:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];

  imem_loadable #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .stall      (stall),
    .flush      (flush),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .fault      (fault),
    .ld_start   (ld_start),
    .ld_end     (ld_end),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_ready   (ld_ready),
    .ld_busy    (ld_busy),
    .ld_words   (ld_words),
    .ld_state   (ld_state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_fetch(input string tag);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s got=empty_queue exp=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {30'd0, inst_valid, fault, inst_out}, {30'd0, e});
    end
  endtask

  task automatic push_idle();
    exp_q.push_back({1'b0, 1'b0, NOP});
  endtask

  task automatic do_fetch(input logic [31:0] pc, input string tag);
    logic bad;
    bad = (pc[1:0] != 2'b00) || (pc[31:8] != 24'd0);
    exp_q.push_back({1'b1, bad, bad ? NOP : model_mem[pc[7:2]]});
    fetch_req = 1'b1;
    fetch_pc  = pc;
    tick();
    fetch_req = 1'b0;
    check_fetch(tag);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!ld_ready && n < 8) begin
      tick();
      n++;
    end
    chk("ld_ready_wait", {63'd0, ld_ready}, 64'd1);
    ld_valid = 1'b1;
    ld_byte  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] new_w;
    int          wi;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    rst_n = 1'b0; fetch_req = 1'b0; fetch_pc = 32'd0; stall = 1'b0; flush = 1'b0;
    ld_start = 1'b0; ld_end = 1'b0; ld_valid = 1'b0; ld_byte = 8'd0;

    // reset values
    @(negedge clk);
    tick();
    chk("rst_inst_out", {32'd0, inst_out}, {32'd0, NOP});
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
    chk("rst_ld_busy", {63'd0, ld_busy}, 64'd0);
    chk("rst_ld_words", {57'd0, ld_words}, 64'd0);
    chk("rst_state", {62'd0, ld_state}, {62'd0, L_IDLE});
    rst_n = 1'b1;
    tick();

    // first fetch from power-up content
    do_fetch(32'h0, "fetch_pc0_init");
    fetch_req = 1'b0;
    push_idle();
    tick();
    check_fetch("idle_after_fetch");

    // load one word; a fetch with ld_start is lost
    fetch_req = 1'b1; fetch_pc = 32'h0; ld_start = 1'b1;
    push_idle();
    tick();
    ld_start = 1'b0; fetch_req = 1'b0;
    check_fetch("fetch_lost_on_start");
    chk("busy_after_start", {63'd0, ld_busy}, 64'd1);
    chk("ready_after_start", {63'd0, ld_ready}, 64'd1);
    send_byte(8'h13); send_byte(8'h0F); send_byte(8'h10);
    fetch_req = 1'b1;
    send_byte(8'h00);
    chk("ready_low_in_wr", {63'd0, ld_ready}, 64'd0);
    chk("state_wr", {62'd0, ld_state}, {62'd0, L_WR});
    push_idle();
    tick();
    fetch_req = 1'b0;
    check_fetch("fetch_blocked_busy");
    chk("ready_back_after_wr", {63'd0, ld_ready}, 64'd1);
    ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
    chk("busy_after_end1", {63'd0, ld_busy}, 64'd0);
    chk("words_load1", {57'd0, ld_words}, 64'd1);
    model_mem[0] = 32'h00100F13;
    do_fetch(32'h0, "fetch_loaded_w0");

    // fault decode
    do_fetch(32'h102, "fetch_misaligned");
    do_fetch(32'h100, "fetch_out_of_range");
    do_fetch(32'hFC, "fetch_last_word");
    do_fetch(32'h80000000, "fetch_high_bit");

    // stall holds, flush wins over stall
    do_fetch(32'h0, "fetch_before_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1;
      fetch_pc  = 32'($urandom_range(1, 63)) * 32'd4;
      exp_q.push_back({1'b1, 1'b0, model_mem[0]});
      tick();
      check_fetch("stall_hold");
    end
    flush = 1'b1;
    push_idle();
    tick();
    check_fetch("flush_over_stall");
    flush = 1'b0; stall = 1'b0; fetch_req = 1'b0;
    do_fetch(32'h102, "fetch_fault_before_flush");
    flush = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h4;
    push_idle();
    tick();
    check_fetch("flush_clears_fault");
    flush = 1'b0; fetch_req = 1'b0;

    // 6 bytes then ld_end: word 1 partial is discarded
    pulse_start();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22);
    ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
    chk("busy_after_end2", {63'd0, ld_busy}, 64'd0);
    chk("words_load2", {57'd0, ld_words}, 64'd1);
    model_mem[0] = 32'hDDCCBBAA;
    do_fetch(32'h0, "fetch_partial_w0");
    do_fetch(32'h4, "fetch_partial_w1_nop");

    // full load without ld_end
    pulse_start();
    for (int w = 0; w < DEPTH; w++) begin
      word = $urandom;
      for (int k = 0; k < 4; k++) send_byte(word[k*8 +: 8]);
      model_mem[w] = word;
    end
    tick();
    chk("full_state_idle", {62'd0, ld_state}, {62'd0, L_IDLE});
    chk("full_busy", {63'd0, ld_busy}, 64'd0);
    chk("full_words", {57'd0, ld_words}, 64'(DEPTH));
    do_fetch(32'h0, "full_w0");
    do_fetch(32'hFC, "full_wlast");
    for (int i = 0; i < 4; i++) begin
      wi = $urandom_range(1, DEPTH - 2);
      do_fetch(32'(wi) * 32'd4, "full_rand");
    end

    // reset in the middle of a load
    pulse_start();
    new_w = $urandom;
    for (int k = 0; k < 4; k++) send_byte(new_w[k*8 +: 8]);
    send_byte(8'h5A);
    model_mem[0] = new_w;
    chk("midload_busy", {63'd0, ld_busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_immediate", {63'd0, ld_busy}, 64'd0);
    chk("rst_state_immediate", {62'd0, ld_state}, {62'd0, L_IDLE});
    chk("rst_words_immediate", {57'd0, ld_words}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_fetch(32'h0, "after_rst_w0");
    do_fetch(32'h4, "after_rst_w1");

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
